// File: rtl/signed_divider_pkg.sv
// Shared types and width helpers for the iterative signed divider.
package signed_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Step counter must hold the value n itself, not just n-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Largest positive w-bit two's complement value (2^(w-1)-1), zero-extended to 64 bits.
    function automatic logic [63:0] qmax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative w-bit two's complement value (-2^(w-1)); the low w bits are the result.
    function automatic logic [63:0] qmin(input int w);
        return ~qmax(w);
    endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Start/operand request and result/status bus of the signed divider.
interface signed_divider_if #(
    parameter int N_W = 16,
    parameter int D_W = 8
);
    logic                  start;
    logic signed [N_W-1:0] dividend;
    logic signed [D_W-1:0] divisor;
    logic                  busy;
    logic                  done;
    logic signed [N_W-1:0] quotient;
    logic signed [D_W-1:0] remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor magnitude.
module signed_divider_step #(
    parameter int D_W = 8
) (
    input  logic [D_W:0]   rem_i,
    input  logic           bit_i,
    input  logic [D_W-1:0] dvs_i,
    output logic [D_W:0]   rem_o,
    output logic           qbit_o
);
    logic [D_W+1:0] shifted;
    logic [D_W+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, dvs_i};
        qbit_o  = (shifted >= {2'b00, dvs_i});
        // A valid partial remainder is always below |divisor|, so the top bit is never needed.
        rem_o   = (D_W + 1)'(qbit_o ? diff : shifted);
    end
endmodule

// File: rtl/signed_divider.sv
// Fixed-latency radix-2 signed divider: magnitude restoring division, then sign fix-up.
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int N_W = 16,
    parameter int D_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    signed_divider_if.slave bus
);
    localparam int             CNT_W  = cnt_width(N_W);
    localparam logic [N_W-1:0] Q_MAX  = N_W'(qmax(N_W));
    localparam logic [N_W-1:0] Q_MIN  = N_W'(qmin(N_W));

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_n_q, neg_n_d;
    logic             neg_v_q, neg_v_d;
    logic [N_W-1:0]   dvd_q, dvd_d;
    logic [D_W-1:0]   dvs_q, dvs_d;
    logic [D_W:0]     prem_q, prem_d;
    logic [D_W-1:0]   raw_r_q, raw_r_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N_W-1:0]   quo_q, quo_d;
    logic [D_W-1:0]   rem_q, rem_d;
    logic             dbz_o_q, dbz_o_d;
    logic             ovf_o_q, ovf_o_d;

    logic [D_W:0]     prem_step;
    logic             qbit_step;

    signed_divider_step #(.D_W(D_W)) u_step (
        .rem_i  (prem_q),
        .bit_i  (dvd_q[N_W-1]),
        .dvs_i  (dvs_q),
        .rem_o  (prem_step),
        .qbit_o (qbit_step)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_n_d = neg_n_q;
        neg_v_d = neg_v_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        raw_r_d = raw_r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_o_d = dbz_o_q;
        ovf_o_d = ovf_o_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    neg_n_d = bus.dividend[N_W-1];
                    neg_v_d = bus.divisor[D_W-1];
                    dvd_d   = bus.dividend[N_W-1] ? -bus.dividend : bus.dividend;
                    dvs_d   = bus.divisor[D_W-1] ? -bus.divisor : bus.divisor;
                    prem_d  = '0;
                    cnt_d   = CNT_W'(N_W);
                    raw_r_d = bus.dividend[D_W-1:0];
                    dbz_d   = (bus.divisor == '0);
                    ovf_d   = (bus.dividend == Q_MIN) && (bus.divisor == '1);
                end
            end
            RUN: begin
                // Quotient bits shift into the vacated low end of the dividend magnitude.
                prem_d = prem_step;
                dvd_d  = {dvd_q[N_W-2:0], qbit_step};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_o_d = dbz_q;
                ovf_o_d = ovf_q;
                if (dbz_q) begin
                    quo_d = neg_n_q ? Q_MIN : Q_MAX;
                    rem_d = raw_r_q;
                end else if (ovf_q) begin
                    quo_d = Q_MAX;
                    rem_d = '0;
                end else begin
                    quo_d = (neg_n_q ^ neg_v_q) ? -dvd_q : dvd_q;
                    rem_d = neg_n_q ? -prem_q[D_W-1:0] : prem_q[D_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: no memories here, so every register takes the asynchronous reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            neg_n_q <= 1'b0;
            neg_v_q <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            raw_r_q <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_o_q <= 1'b0;
            ovf_o_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            cnt_q   <= cnt_d;
            neg_n_q <= neg_n_d;
            neg_v_q <= neg_v_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            raw_r_q <= raw_r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_o_q <= dbz_o_d;
            ovf_o_q <= ovf_o_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_o_q;
    assign bus.overflow    = ovf_o_q;

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: driver queues hand-computed results, monitor checks on done.
module tb_signed_divider;
    localparam int N_W = 16;
    localparam int D_W = 8;
    localparam int LAT = N_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    signed_divider_if #(.N_W(N_W), .D_W(D_W)) dif ();

    signed_divider #(.N_W(N_W), .D_W(D_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    q;
        int    r;
        bit    dbz;
        bit    ovf;
        int    start_cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        bit   prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) check("done_pulse_width", int'(dif.done), 0);
            if (dif.done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done with no pending operation at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_q"},       int'(dif.quotient),    e.q);
                    check({e.name, "_r"},       int'(dif.remainder),   e.r);
                    check({e.name, "_dbz"},     int'(dif.div_by_zero), int'(e.dbz));
                    check({e.name, "_ovf"},     int'(dif.overflow),    int'(e.ovf));
                    check({e.name, "_latency"}, cyc - e.start_cyc,     LAT);
                end
            end
            prev_done = dif.done;
        end
    end

    task automatic issue(input int a, input int b, input int q, input int r,
                         input bit dbz, input bit ovf, input string name);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (dif.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (dif.busy) begin
            total++;
            bad++;
            $display("FAIL %s_wait: busy still 1 after %0d cycles", name, guard);
        end
        dif.start    = 1'b1;
        dif.dividend = N_W'(a);
        dif.divisor  = D_W'(b);
        e = '{q, r, dbz, ovf, cyc + 1, name};
        sb.push_back(e);
        @(negedge clk);
        dif.start = 1'b0;
        check({name, "_busy"}, int'(dif.busy), 1);
    endtask

    task automatic pulse_start(input int a, input int b);
        dif.start    = 1'b1;
        dif.dividend = N_W'(a);
        dif.divisor  = D_W'(b);
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 4 * LAT) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(dif.busy),        0);
        check({tag, "_done"}, int'(dif.done),        0);
        check({tag, "_q"},    int'(dif.quotient),    0);
        check({tag, "_r"},    int'(dif.remainder),   0);
        check({tag, "_dbz"},  int'(dif.div_by_zero), 0);
        check({tag, "_ovf"},  int'(dif.overflow),    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        issue(100, 7, 14, 2, 1'b0, 1'b0, "p100_p7");
        drain();

        // Sign combinations, issued back to back.
        issue(-100,  7, -14, -2, 1'b0, 1'b0, "n100_p7");
        issue( 100, -7, -14,  2, 1'b0, 1'b0, "p100_n7");
        issue(-100, -7,  14, -2, 1'b0, 1'b0, "n100_n7");
        drain();

        // Boundaries.
        issue(-32768, -1,   32767, 0,  1'b0, 1'b1, "min_n1");
        issue(-32768,  1,  -32768, 0,  1'b0, 1'b0, "min_p1");
        issue(   127, -128,     0, 127, 1'b0, 1'b0, "p127_n128");
        issue( 32767,  127,   258, 1,  1'b0, 1'b0, "max_p127");
        issue(-32767,    3, -10922, -1, 1'b0, 1'b0, "n32767_p3");
        drain();

        // Divide by zero, then a valid operation clears the flag.
        issue( 5, 0,  32767,  5, 1'b1, 1'b0, "p5_div0");
        issue(-5, 0, -32768, -5, 1'b1, 1'b0, "n5_div0");
        issue(100, 7, 14, 2, 1'b0, 1'b0, "clear_dbz");
        drain();

        // Starts during a run are ignored.
        issue(1000, -9, -111, 1, 1'b0, 1'b0, "ignore_busy");
        repeat (2) @(negedge clk);
        pulse_start(50, 5);
        repeat (4) @(negedge clk);
        pulse_start(-60, 3);
        drain();

        // Start in the done cycle of the previous operation.
        issue( 7, 2,  3,  1, 1'b0, 1'b0, "b2b_first");
        issue(-9, 4, -2, -1, 1'b0, 1'b0, "b2b_second");
        drain();

        // Reset in the middle of a run aborts it without a done.
        issue(100, 7, 14, 2, 1'b0, 1'b0, "aborted");
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        issue(100, 7, 14, 2, 1'b0, 1'b0, "after_reset");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
